mac4_dot_ctrl: RTL and testbench

Sequencing controller that computes one fixed-point dot product of arbitrary length on a single shared combinational 4-lane MAC (Q2.14 products, each lane arithmetically shifted right by 14, summed to 2*DATA_WIDTH bits). It accepts 4-lane operand beats over a valid/ready stream and registers them onto the MAC inputs. It accumulates the MAC result per beat, masks unused lanes of the final partial beat, and returns a saturated result over a valid/ready output. It sits between the LSTM gate-weight fetch logic and the MAC instance.

---
 rtl/mac4_dot_ctrl_if.sv | 29 ++
 rtl/mac4_dot_ctrl.sv | 85 ++++++++
 tb/tb_mac4_dot_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mac4_dot_ctrl_if.sv
// mac4_dot_ctrl_if: command, operand, MAC and result signals of the dot-product controller
interface mac4_dot_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH = 8,
  parameter int ACC_WIDTH = 32
);
  logic start;
  logic [LEN_WIDTH-1:0] len;
  logic busy;
  logic in_valid;
  logic in_ready;
  logic [4*DATA_WIDTH-1:0] in_a;
  logic [4*DATA_WIDTH-1:0] in_b;
  logic [4*DATA_WIDTH-1:0] mac_a;
  logic [4*DATA_WIDTH-1:0] mac_b;
  logic [2*DATA_WIDTH-1:0] mac_result;
  logic out_valid;
  logic out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [DATA_WIDTH-1:0] out_data;
  modport slave (
    input start, len, in_valid, in_a, in_b, mac_result, out_ready,
    output busy, in_ready, mac_a, mac_b, out_valid, out_acc, out_data
  );
  modport master (
    output start, len, in_valid, in_a, in_b, mac_result, out_ready,
    input busy, in_ready, mac_a, mac_b, out_valid, out_acc, out_data
  );
endinterface

// File: rtl/mac4_dot_ctrl.sv
// mac4_dot_ctrl: sequences an arbitrary-length Q2.14 dot product over a shared 4-lane MAC
module mac4_dot_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  mac4_dot_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] beats_q, beats_d;
  logic [1:0] rem_q, rem_d;
  logic [4*DATA_WIDTH-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, lane_mask;
  logic stage_v_q, stage_v_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_sat;
  logic [ACC_WIDTH:0] sum;
  logic last_part, acc_fits;
  assign last_part = beats_q == LEN_WIDTH'(1) && rem_q != 2'd0;
  for (genvar k = 0; k < 4; k++) begin : g_mask
    assign lane_mask[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{!(last_part && 2'(k) >= rem_q)}};
  end
  assign sum = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-2*DATA_WIDTH){bus.mac_result[2*DATA_WIDTH-1]}}, bus.mac_result};
  assign acc_sat = sum[ACC_WIDTH] != sum[ACC_WIDTH-1]
                 ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){!sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
  assign acc_fits = &acc_q[ACC_WIDTH-1:DATA_WIDTH-1] || ~|acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
  assign bus.out_data = acc_fits ? acc_q[DATA_WIDTH-1:0]
                      : {acc_q[ACC_WIDTH-1], {(DATA_WIDTH-1){!acc_q[ACC_WIDTH-1]}}};
  assign bus.out_acc = acc_q;
  assign bus.mac_a = mac_a_q;
  assign bus.mac_b = mac_b_q;
  assign bus.busy = state_q != IDLE;
  assign bus.in_ready = state_q == RUN && beats_q != '0;
  assign bus.out_valid = state_q == DONE;
  // next state: beat capture with tail masking, per-beat saturating accumulation
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    rem_d = rem_q;
    mac_a_d = '0;
    mac_b_d = '0;
    stage_v_d = 1'b0;
    acc_d = stage_v_q ? acc_sat : acc_q;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d = '0;
        beats_d = LEN_WIDTH'(bus.len[LEN_WIDTH-1:2]) + LEN_WIDTH'(|bus.len[1:0]);
        rem_d = bus.len[1:0];
        state_d = bus.len == '0 ? DONE : RUN;
      end
      RUN: if (bus.in_valid && bus.in_ready) begin
        mac_a_d = bus.in_a & lane_mask;
        mac_b_d = bus.in_b & lane_mask;
        stage_v_d = 1'b1;
        beats_d = beats_q - LEN_WIDTH'(1);
        state_d = beats_q == LEN_WIDTH'(1) ? DRAIN : RUN;
      end
      DRAIN: state_d = DONE;
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously so an aborted run leaves no residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beats_q <= '0;
      rem_q <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      stage_v_q <= 1'b0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      rem_q <= rem_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      stage_v_q <= stage_v_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_mac4_dot_ctrl.sv
// tb_mac4_dot_ctrl: directed vector table plus stall, backpressure and reset sequences
module tb_mac4_dot_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_bad = 0;
  mac4_dot_ctrl_if bus ();
  mac4_dot_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mac4(input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] s, pa, pb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      pa = $signed(a[k*16 +: 16]);
      pb = $signed(b[k*16 +: 16]);
      s = s + ((pa * pb) >>> 14);
    end
    return s;
  endfunction
  assign bus.mac_result = mac4(bus.mac_a, bus.mac_b);
  typedef struct {
    int len;
    logic [15:0] a;
    logic [15:0] b;
    int acc;
    int data;
  } vec_t;
  vec_t vecs [10];
  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_to_done(input int len, input logic [15:0] a, input logic [15:0] b,
                             input int eacc, input int edata, input int stall);
    int nb, cyc, idx;
    logic saw_ready;
    logic [63:0] ea, eb;
    nb = (len + 3) / 4;
    bus.start = 1'b1;
    bus.len = 8'(len);
    tick();
    bus.start = 1'b0;
    cyc = 0;
    saw_ready = 1'b0;
    for (int beat = 0; beat < nb; beat++) begin
      if (beat == 1) repeat (stall) begin tick(); cyc++; end
      check("in_ready_run", longint'(bus.in_ready), 1);
      for (int k = 0; k < 4; k++) begin
        idx = beat * 4 + k;
        bus.in_a[k*16 +: 16] = idx < len ? a : 16'h7FFF;
        bus.in_b[k*16 +: 16] = idx < len ? b : 16'h7FFF;
        ea[k*16 +: 16] = idx < len ? a : 16'h0000;
        eb[k*16 +: 16] = idx < len ? b : 16'h0000;
      end
      bus.in_valid = 1'b1;
      tick();
      cyc++;
      bus.in_valid = 1'b0;
      check("mac_a_beat", longint'(bus.mac_a), longint'(ea));
      check("mac_b_beat", longint'(bus.mac_b), longint'(eb));
    end
    saw_ready = bus.in_ready;
    while (!bus.out_valid && cyc < nb + stall + 10) begin
      tick();
      cyc++;
      saw_ready |= bus.in_ready;
    end
    check("out_valid", longint'(bus.out_valid), 1);
    check("latency", cyc, len == 0 ? 0 : nb + 1 + stall);
    check("out_acc", longint'($signed(bus.out_acc)), eacc);
    check("out_data", longint'($signed(bus.out_data)), edata);
    if (len == 0) check("in_ready_len0", longint'(saw_ready), 0);
  endtask
  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_busy", longint'(bus.busy), 0);
    check("idle_out_valid", longint'(bus.out_valid), 0);
  endtask
  initial begin
    vecs[0] = '{4, 16'h4000, 16'h2000, 32768, 32767};
    vecs[1] = '{6, 16'h4000, 16'h1000, 24576, 24576};
    vecs[2] = '{8, 16'hC000, 16'h4000, -131072, -32768};
    vecs[3] = '{0, 16'h0000, 16'h0000, 0, 0};
    vecs[4] = '{1, 16'h2000, 16'h2000, 4096, 4096};
    vecs[5] = '{3, 16'hE000, 16'h2000, -12288, -12288};
    vecs[6] = '{5, 16'h7FFF, 16'h7FFF, 327660, 32767};
    vecs[7] = '{2, 16'hFFFF, 16'h0001, -2, -2};
    vecs[8] = '{255, 16'h4000, 16'h4000, 4177920, 32767};
    vecs[9] = '{7, 16'h2000, 16'hC000, -57344, -32768};
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_acc", longint'(bus.out_acc), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    #3 rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      run_to_done(vecs[i].len, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].data, 0);
      accept();
    end
    run_to_done(8, 16'h4000, 16'h4000, 131072, 32767, 3);
    for (int i = 0; i < 5; i++) begin
      bus.start = i == 2;
      bus.len = 8'd4;
      bus.in_valid = 1'b1;
      bus.in_a = {4{16'h4000}};
      bus.in_b = {4{16'h4000}};
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      check("hold_out_valid", longint'(bus.out_valid), 1);
      check("hold_out_acc", longint'($signed(bus.out_acc)), 131072);
      check("hold_mac_a", longint'(bus.mac_a), 0);
    end
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    tick();
    check("start_in_done_ignored", longint'(bus.busy), 0);
    bus.start = 1'b1;
    bus.len = 8'd12;
    tick();
    bus.start = 1'b0;
    bus.in_a = {4{16'h4000}};
    bus.in_b = {4{16'h4000}};
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_in_ready", longint'(bus.in_ready), 0);
    check("abort_out_valid", longint'(bus.out_valid), 0);
    check("abort_mac_a", longint'(bus.mac_a), 0);
    check("abort_mac_b", longint'(bus.mac_b), 0);
    check("abort_out_acc", longint'(bus.out_acc), 0);
    check("abort_out_data", longint'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_to_done(4, 16'h4000, 16'h2000, 32768, 32767, 0);
    accept();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
